// File: rtl/display_digit_scanner_pkg.sv
// display_digit_scanner_pkg: shared display types, digit-enable constants and default timing.
package display_digit_scanner_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;
  localparam logic [3:0] DIGITS_OFF       = 4'b1111;
  localparam int         DEF_DIV_WIDTH    = 16;
  localparam int         DEF_DIV_MAX      = 49999;
  localparam int         DEF_BLANK_CYCLES = 8;
  function automatic logic [3:0] digit_sel(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction
endpackage

// File: rtl/display_digit_scanner_refresh_prescaler.sv
// refresh_prescaler: clearable up-counter flagging terminal at MAX (clk, rst_n, clear, run, terminal).
module refresh_prescaler
  import display_digit_scanner_pkg::*;
#(
  parameter int WIDTH = DEF_DIV_WIDTH,
  parameter int MAX   = DEF_DIV_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic terminal
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : run ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  assign terminal = count_q == WIDTH'(MAX);
endmodule

// File: rtl/display_digit_scanner.sv
// display_digit_scanner: scans 4 active-low digits with dead-time (clk, rst_n, enable -> index, digito, blank, scanTick).
module display_digit_scanner
  import display_digit_scanner_pkg::*;
#(
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
  parameter int DIV_MAX      = DEF_DIV_MAX,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] digito,
  output logic       blank,
  output logic       scanTick
);
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be >= 1");
  end
  scan_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  digito_q, digito_d;
  logic        blank_q, blank_d;
  logic        pre_term, blk_term;
  // The blank counter counts up 0..BLANK_CYCLES-1, giving the same dwell as a down-count.
  refresh_prescaler #(.WIDTH(DIV_WIDTH), .MAX(DIV_MAX)) u_pre (
    .clk(clk), .rst_n(rst_n),
    .clear(state_q != ST_SHOW || pre_term || !enable),
    .run(state_q == ST_SHOW),
    .terminal(pre_term)
  );
  refresh_prescaler #(.WIDTH(BW), .MAX(BLANK_CYCLES - 1)) u_blk (
    .clk(clk), .rst_n(rst_n),
    .clear(state_q != ST_BLANK || blk_term || !enable),
    .run(state_q == ST_BLANK),
    .terminal(blk_term)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (state_q == ST_IDLE) state_d = ST_SHOW;
    else if (state_q == ST_SHOW && pre_term) begin
      state_d = ST_BLANK;
      idx_d   = idx_q + 2'd1;
    end else if (state_q == ST_BLANK && blk_term) state_d = ST_SHOW;
    digito_d = state_d == ST_SHOW ? digit_sel(idx_d) : DIGITS_OFF;
    blank_d  = state_d != ST_SHOW;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      digito_q <= DIGITS_OFF;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      digito_q <= digito_d;
      blank_q  <= blank_d;
    end
  assign saida1Contador = idx_q[1];
  assign saida2Contador = idx_q[0];
  assign digito         = digito_q;
  assign blank          = blank_q;
  // Disable wins over the terminal count, so the tick is gated by the live enable.
  assign scanTick       = state_q == ST_SHOW && pre_term && enable;
endmodule

// File: tb/tb_display_digit_scanner.sv
// tb_display_digit_scanner: randomized bench with a timeline model for two parameter sets.
module tb_display_digit_scanner;
  logic       clk = 0, rst_n = 0, enable = 0;
  logic       a_s1, a_s2, a_blank, a_tick, b_s1, b_s2, b_blank, b_tick;
  logic [3:0] a_dig, b_dig;
  int         checks = 0, errors = 0;
  bit         run = 0;
  int         t = 0;
  logic [1:0] prev_a = 0, prev_b = 0;
  always #5 clk = ~clk;

  display_digit_scanner #(.DIV_WIDTH(4), .DIV_MAX(3), .BLANK_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .saida1Contador(a_s1), .saida2Contador(a_s2),
    .digito(a_dig), .blank(a_blank), .scanTick(a_tick));
  display_digit_scanner #(.DIV_WIDTH(2), .DIV_MAX(0), .BLANK_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .saida1Contador(b_s1), .saida2Contador(b_s2),
    .digito(b_dig), .blank(b_blank), .scanTick(b_tick));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time t since the scan started; each digit occupies d+1 lit then b dark cycles.
  function automatic void calc(input int d, input int b, input int tt, input bit r, input bit en,
                               output logic [3:0] dg, output logic [1:0] ix,
                               output logic bl, output logic tk);
    int p, k, ph;
    dg = 4'hF; ix = 0; bl = 1; tk = 0;
    if (r) begin
      p = d + 1 + b; k = tt / p; ph = tt % p;
      if (ph <= d) begin
        ix = 2'(k % 4); dg = ~(4'b1000 >> ix); bl = 0; tk = (ph == d) && en;
      end else ix = 2'((k + 1) % 4);
    end
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 0; t <= 0;
    end else if (enable) begin
      t <= run ? t + 1 : 0; run <= 1;
    end else begin
      run <= 0; t <= 0;
    end

  always @(negedge clk) begin
    logic [3:0] dg; logic [1:0] ix; logic bl, tk;
    calc(3, 2, t, run, enable, dg, ix, bl, tk);
    chk("a_digito", a_dig, dg); chk("a_idx", {a_s1, a_s2}, ix);
    chk("a_blank", a_blank, bl); chk("a_tick", a_tick, tk);
    chk("a_deadtime", ({a_s1, a_s2} != prev_a && a_dig != 4'hF), 0);
    chk("a_onehot", $countones(~a_dig) <= 1, 1);
    prev_a = {a_s1, a_s2};
    calc(0, 1, t, run, enable, dg, ix, bl, tk);
    chk("b_digito", b_dig, dg); chk("b_idx", {b_s1, b_s2}, ix);
    chk("b_blank", b_blank, bl); chk("b_tick", b_tick, tk);
    chk("b_deadtime", ({b_s1, b_s2} != prev_b && b_dig != 4'hF), 0);
    chk("b_onehot", $countones(~b_dig) <= 1, 1);
    prev_b = {b_s1, b_s2};
  end

  task automatic check_restart();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("restart_digito", a_dig, 4'h7); chk("restart_idx", {a_s1, a_s2}, 0);
    end
    @(negedge clk);
    chk("restart_dark", a_dig, 4'hF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq_a [24] = '{4'h7,4'h7,4'h7,4'h7,4'hF,4'hF, 4'hB,4'hB,4'hB,4'hB,4'hF,4'hF,
                               4'hD,4'hD,4'hD,4'hD,4'hF,4'hF, 4'hE,4'hE,4'hE,4'hE,4'hF,4'hF};
    logic [1:0] idx_a [24] = '{0,0,0,0,1,1, 1,1,1,1,2,2, 2,2,2,2,3,3, 3,3,3,3,0,0};
    logic [3:0] seq_b [8]  = '{4'h7,4'hF,4'hB,4'hF,4'hD,4'hF,4'hE,4'hF};
    logic [1:0] idx_b [8]  = '{0,1,1,2,2,3,3,0};
    int ticks, n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("reset_digito", a_dig, 4'hF); chk("reset_blank", a_blank, 1);
    @(posedge clk); #2 enable = 1;
    @(posedge clk);
    ticks = 0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (c < 24) begin
        chk("seq_a", a_dig, seq_a[c]); chk("seq_idx_a", {a_s1, a_s2}, idx_a[c]);
      end
      if (c < 8) begin
        chk("seq_b", b_dig, seq_b[c]); chk("seq_idx_b", {b_s1, b_s2}, idx_b[c]);
      end
      if (a_tick) begin
        ticks++;
        chk("tick_pos", c % 6, 3);
      end
    end
    chk("tick_count", ticks, 12);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("async_digito", a_dig, 4'hF); chk("async_blank", a_blank, 1);
    chk("async_idx", {a_s1, a_s2}, 0); chk("async_tick", a_tick, 0);
    @(posedge clk); #2 rst_n = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_tick && n < 50);
    chk("wait_tick", a_tick, 1);
    @(posedge clk); #2 enable = 0;
    @(negedge clk); chk("blank_phase", a_blank, 1);
    @(negedge clk);
    chk("dis_blank_digito", a_dig, 4'hF); chk("dis_blank_idx", {a_s1, a_s2}, 0);
    chk("dis_blank_tick", a_tick, 0);
    @(posedge clk); #2 enable = 1;
    check_restart();
    n = 0;
    do begin @(negedge clk); n++; end while (!(run && t % 6 == 2) && n < 50);
    chk("wait_pre2", run && t % 6 == 2, 1);
    @(posedge clk); #2 enable = 0;
    @(negedge clk);
    chk("coinc_tick", a_tick, 0); chk("coinc_lit", a_dig != 4'hF, 1);
    @(negedge clk);
    chk("coinc_digito", a_dig, 4'hF); chk("coinc_idx", {a_s1, a_s2}, 0);
    @(posedge clk); #2 enable = 1;
    check_restart();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < (enable ? 2 : 20)) enable = ~enable;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0; #1 rst_n = 1;
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
